// File: rtl/icosoc_mod_adc_capture.sv
`default_nettype none
// ============================================================================
// Module   : icosoc_mod_adc_capture
// Purpose  : Triggered capture of the 8-bit ADC sample stream. The stream is
//            decimated, then a level/edge (or immediate) trigger starts a
//            block capture into an on-chip buffer. The CPU reads the buffer
//            through the icosoc ctrl register bus.
// Ports    : clk, resetn (sync, active low)
//            ctrl_wr/ctrl_rd/ctrl_addr/ctrl_wdat -> ctrl_rdat/ctrl_done
//            sample_data/sample_valid            upstream ADC byte stream
//            capture_done (level), trig_pulse (one cycle)
// Revision : 1.0 - initial release
// ============================================================================
module icosoc_mod_adc_capture #(
  parameter int CLOCK_FREQ_HZ = 0,
  parameter int ADDR_BITS     = 9
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [3:0]  ctrl_wr,
  input  logic        ctrl_rd,
  input  logic [15:0] ctrl_addr,
  input  logic [31:0] ctrl_wdat,
  output logic [31:0] ctrl_rdat,
  output logic        ctrl_done,
  input  logic [7:0]  sample_data,
  input  logic        sample_valid,
  output logic        capture_done,
  output logic        trig_pulse
);

  localparam int                 DEPTH   = 2 ** ADDR_BITS;
  localparam logic [16:0]        DEPTH_W = 17'(DEPTH);
  localparam logic [ADDR_BITS:0] DEPTH_P = (ADDR_BITS + 1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t               state_q;
  // Live configuration (CPU-visible) and shadow copies latched at arm.
  logic [7:0]           level_q, sh_level_q;
  logic                 edge_q, sh_edge_q;
  logic                 imm_q, sh_imm_q;
  logic [15:0]          decim_q, sh_decim_q;
  logic [15:0]          count_q;
  logic [ADDR_BITS:0]   sh_count_q;
  logic [ADDR_BITS:0]   wr_ptr_q, rd_ptr_q;
  logic                 triggered_q, prev_valid_q;
  logic [7:0]           prev_q;
  logic [15:0]          dcnt_q;
  logic                 ctrl_done_q, trig_pulse_q, data_pend_q, rd_valid_q;
  logic [31:0]          ctrl_rdat_q;
  logic [7:0]           rd_byte_q;
  logic [7:0]           mem_q [DEPTH];

  logic                 req_d, data_rd_d, qual_d, hit_d, fire_d, cap_wr_d;
  logic [ADDR_BITS-1:0] mem_addr_d;
  logic [ADDR_BITS:0]   cnt_eff_d;
  logic [15:0]          decim_eff_d;
  logic [31:0]          rd_mux_d;

  always_comb begin
    // A DATA read occupies two cycles; its second cycle is not a new request.
    req_d      = (ctrl_rd || (ctrl_wr != 4'd0)) && !ctrl_done_q && !data_pend_q;
    data_rd_d  = req_d && ctrl_rd && (ctrl_addr == 16'h0010);
    qual_d     = sample_valid && (dcnt_q == 16'd0);
    hit_d      = sh_edge_q ? ((prev_q > sh_level_q) && (sample_data <= sh_level_q))
                           : ((prev_q < sh_level_q) && (sample_data >= sh_level_q));
    fire_d     = (state_q == ST_ARMED) && qual_d && (sh_imm_q || (prev_valid_q && hit_d));
    cap_wr_d   = (state_q == ST_CAPTURE) && qual_d && (wr_ptr_q < sh_count_q);
    mem_addr_d = fire_d ? '0 : wr_ptr_q[ADDR_BITS-1:0];
    decim_eff_d = (decim_q == 16'd0) ? 16'd1 : decim_q;
    if ((count_q == 16'd0) || ({1'b0, count_q} > DEPTH_W)) cnt_eff_d = DEPTH_P;
    else                                                   cnt_eff_d = count_q[ADDR_BITS:0];
    case (ctrl_addr)
      16'h0000: rd_mux_d = {16'(wr_ptr_q), 7'd0, triggered_q, 6'd0, state_q};
      16'h0004: rd_mux_d = {22'd0, imm_q, edge_q, level_q};
      16'h0008: rd_mux_d = {16'd0, decim_q};
      16'h000C: rd_mux_d = {16'd0, count_q};
      16'h0014: rd_mux_d = 32'(rd_ptr_q);
      default:  rd_mux_d = 32'd0;
    endcase
  end

  // Buffer storage and registered read port; no reset so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (fire_d || cap_wr_d) mem_q[mem_addr_d] <= sample_data;
    if (data_rd_d)          rd_byte_q <= mem_q[rd_ptr_q[ADDR_BITS-1:0]];
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      level_q      <= 8'h80;  sh_level_q <= 8'h80;
      edge_q       <= 1'b0;   sh_edge_q  <= 1'b0;
      imm_q        <= 1'b0;   sh_imm_q   <= 1'b0;
      decim_q      <= 16'd1;  sh_decim_q <= 16'd1;
      count_q      <= 16'd0;  sh_count_q <= DEPTH_P;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      triggered_q  <= 1'b0;
      prev_valid_q <= 1'b0;
      prev_q       <= 8'd0;
      dcnt_q       <= 16'd0;
      ctrl_done_q  <= 1'b0;
      ctrl_rdat_q  <= 32'd0;
      trig_pulse_q <= 1'b0;
      data_pend_q  <= 1'b0;
      rd_valid_q   <= 1'b0;
    end else begin
      ctrl_done_q  <= 1'b0;
      ctrl_rdat_q  <= 32'd0;
      trig_pulse_q <= 1'b0;

      if (sample_valid)
        dcnt_q <= (dcnt_q == 16'd0) ? (sh_decim_q - 16'd1) : (dcnt_q - 16'd1);

      case (state_q)
        ST_ARMED: if (qual_d) begin
          prev_q       <= sample_data;
          prev_valid_q <= 1'b1;
          if (fire_d) begin
            triggered_q  <= 1'b1;
            trig_pulse_q <= 1'b1;
            wr_ptr_q     <= (ADDR_BITS + 1)'(1);
            state_q      <= (sh_count_q == (ADDR_BITS + 1)'(1)) ? ST_DONE : ST_CAPTURE;
          end
        end
        ST_CAPTURE: if (cap_wr_d) begin
          wr_ptr_q <= wr_ptr_q + 1'b1;
          if (wr_ptr_q + 1'b1 == sh_count_q) state_q <= ST_DONE;
        end
        default: ;
      endcase

      // Bus commands come last so arm/abort override sample activity.
      if (data_pend_q) begin
        data_pend_q <= 1'b0;
        ctrl_done_q <= 1'b1;
        ctrl_rdat_q <= rd_valid_q ? {1'b1, 23'd0, rd_byte_q} : 32'd0;
      end else if (data_rd_d) begin
        data_pend_q <= 1'b1;
        rd_valid_q  <= (rd_ptr_q < wr_ptr_q);
        if (rd_ptr_q < wr_ptr_q) rd_ptr_q <= rd_ptr_q + 1'b1;
      end else if (req_d) begin
        ctrl_done_q <= 1'b1;
        if (ctrl_rd) ctrl_rdat_q <= rd_mux_d;
        case (ctrl_addr)
          16'h0000: if (ctrl_wr[0]) begin
            if (ctrl_wdat[1]) begin
              state_q      <= ST_IDLE;
              trig_pulse_q <= 1'b0;
            end else if (ctrl_wdat[0]) begin
              sh_level_q   <= level_q;
              sh_edge_q    <= edge_q;
              sh_imm_q     <= imm_q;
              sh_decim_q   <= decim_eff_d;
              sh_count_q   <= cnt_eff_d;
              wr_ptr_q     <= '0;
              rd_ptr_q     <= '0;
              triggered_q  <= 1'b0;
              prev_valid_q <= 1'b0;
              dcnt_q       <= 16'd0;
              trig_pulse_q <= 1'b0;
              state_q      <= ST_ARMED;
            end
          end
          16'h0004: begin
            if (ctrl_wr[0]) level_q <= ctrl_wdat[7:0];
            if (ctrl_wr[1]) begin
              edge_q <= ctrl_wdat[8];
              imm_q  <= ctrl_wdat[9];
            end
          end
          16'h0008: begin
            if (ctrl_wr[0]) decim_q[7:0]  <= ctrl_wdat[7:0];
            if (ctrl_wr[1]) decim_q[15:8] <= ctrl_wdat[15:8];
          end
          16'h000C: begin
            if (ctrl_wr[0]) count_q[7:0]  <= ctrl_wdat[7:0];
            if (ctrl_wr[1]) count_q[15:8] <= ctrl_wdat[15:8];
          end
          16'h0014: if (ctrl_wr != 4'd0) rd_ptr_q <= '0;
          default: ;
        endcase
      end
    end
  end

  assign ctrl_done    = ctrl_done_q;
  assign ctrl_rdat    = ctrl_rdat_q;
  assign trig_pulse   = trig_pulse_q;
  assign capture_done = (state_q == ST_DONE);

  logic unused_ok;
  assign unused_ok = ^{32'(CLOCK_FREQ_HZ), ctrl_wdat[31:16]};

endmodule
`default_nettype wire

// File: tb/tb_icosoc_mod_adc_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_icosoc_mod_adc_capture
// Purpose  : Self-checking bench for icosoc_mod_adc_capture (ADDR_BITS = 4).
//            Directed scenarios plus randomized captures compared against a
//            queue-based reference model of decimation, trigger and capture.
// Revision : 1.0 - initial release
// ============================================================================
module tb_icosoc_mod_adc_capture;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [3:0]  ctrl_wr = 4'd0;
  logic        ctrl_rd = 1'b0;
  logic [15:0] ctrl_addr = 16'd0;
  logic [31:0] ctrl_wdat = 32'd0;
  logic [31:0] ctrl_rdat;
  logic        ctrl_done;
  logic [7:0]  sample_data = 8'd0;
  logic        sample_valid = 1'b0;
  logic        capture_done;
  logic        trig_pulse;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] stim[$];
  logic [7:0] exp_buf[$];

  icosoc_mod_adc_capture #(.CLOCK_FREQ_HZ(0), .ADDR_BITS(4)) dut (
    .clk(clk), .resetn(resetn),
    .ctrl_wr(ctrl_wr), .ctrl_rd(ctrl_rd), .ctrl_addr(ctrl_addr),
    .ctrl_wdat(ctrl_wdat), .ctrl_rdat(ctrl_rdat), .ctrl_done(ctrl_done),
    .sample_data(sample_data), .sample_valid(sample_valid),
    .capture_done(capture_done), .trig_pulse(trig_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expd);
    n_cmp++;
    assert (obs === expd) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expd);
    end
  endtask

  // Read with a bounded wait; checks both the data and the done latency.
  task automatic rd_chk(input string tag, input logic [15:0] a,
                        input logic [31:0] expd, input int exp_lat);
    logic [31:0] d;
    int lat;
    @(negedge clk);
    ctrl_addr = a; ctrl_rd = 1'b1; lat = 0; d = 32'hDEAD_BEEF;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (ctrl_done) begin lat = i; d = ctrl_rdat; break; end
    end
    ctrl_rd = 1'b0;
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk(tag, d, expd);
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] be);
    int lat;
    @(negedge clk);
    ctrl_addr = a; ctrl_wdat = d; ctrl_wr = be; lat = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (ctrl_done) begin lat = i; break; end
    end
    ctrl_wr = 4'd0;
    chk("wr_lat", 32'(lat), 32'd1);
  endtask

  // Feeds one strobe; returns whether trig_pulse answered that sample.
  task automatic feed(input logic [7:0] s, output logic fired);
    @(negedge clk);
    sample_data = s; sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    fired = trig_pulse;
  endtask

  // Reference: qualified samples are every decim-th strobe after arm; find
  // the trigger on that subsequence, then take up to count samples from it.
  task automatic model(input int lvl, input int edg, input int imm, input int decim,
                       input int cnt, output int fire_idx, output int st);
    int d, c, qi[$], k;
    bit fired;
    d = (decim == 0) ? 1 : decim;
    c = (cnt == 0 || cnt > 16) ? 16 : cnt;
    for (int i = 0; i < stim.size(); i++) if (i % d == 0) qi.push_back(i);
    fired = 0; k = 0;
    for (int j = 0; j < qi.size() && !fired; j++) begin
      int cur, prev;
      cur = int'(stim[qi[j]]);
      if (imm != 0) begin fired = 1; k = j; end
      else if (j > 0) begin
        prev = int'(stim[qi[j-1]]);
        if (edg == 0 && prev < lvl && cur >= lvl) begin fired = 1; k = j; end
        if (edg != 0 && prev > lvl && cur <= lvl) begin fired = 1; k = j; end
      end
    end
    exp_buf.delete();
    fire_idx = -1;
    if (fired) begin
      fire_idx = qi[k];
      for (int j = k; j < qi.size() && exp_buf.size() < c; j++) exp_buf.push_back(stim[qi[j]]);
    end
    st = !fired ? 1 : ((exp_buf.size() == c) ? 3 : 2);
  endtask

  task automatic run_capture(input string tag, input int lvl, input int edg, input int imm,
                             input int decim, input int cnt);
    int seen, fire_idx, st;
    logic f;
    wr(16'h0004, {22'd0, imm[0], edg[0], lvl[7:0]}, 4'hF);
    wr(16'h0008, 32'(decim), 4'hF);
    wr(16'h000C, 32'(cnt), 4'hF);
    wr(16'h0000, 32'h1, 4'hF);
    seen = -1;
    for (int i = 0; i < stim.size(); i++) begin
      feed(stim[i], f);
      if (f && seen < 0) seen = i;
    end
    model(lvl, edg, imm, decim, cnt, fire_idx, st);
    chk({tag, "_fire_idx"}, 32'(seen), 32'(fire_idx));
    chk({tag, "_cap_done"}, {31'd0, capture_done}, {31'd0, st == 3});
    rd_chk({tag, "_status"}, 16'h0000,
           {16'(exp_buf.size()), 7'd0, fire_idx >= 0, 6'd0, st[1:0]}, 1);
    for (int i = 0; i < exp_buf.size(); i++)
      rd_chk({tag, "_data"}, 16'h0010, {1'b1, 23'd0, exp_buf[i]}, 2);
    rd_chk({tag, "_data_end"}, 16'h0010, 32'd0, 2);
    rd_chk({tag, "_rdptr"}, 16'h0014, 32'(exp_buf.size()), 1);
  endtask

  initial begin
    logic f;
    repeat (3) @(negedge clk);
    resetn = 1'b1;

    // Reset state
    chk("rst_cap_done", {31'd0, capture_done}, 32'd0);
    chk("rst_trig", {31'd0, trig_pulse}, 32'd0);
    chk("rst_rdat", ctrl_rdat, 32'd0);
    rd_chk("rst_status", 16'h0000, 32'h0000_0000, 1);
    rd_chk("rst_trig_reg", 16'h0004, 32'h0000_0080, 1);
    rd_chk("rst_decim", 16'h0008, 32'h0000_0001, 1);
    rd_chk("unmapped", 16'h0040, 32'd0, 1);

    // Rising edge at 0x80, count 4
    stim = '{8'h10, 8'h7F, 8'h80, 8'h90, 8'hA0, 8'hB0, 8'hC0};
    run_capture("rise", 8'h80, 0, 0, 1, 4);

    // Decimation by 3 with immediate trigger
    stim.delete();
    for (int i = 0; i < 12; i++) stim.push_back(8'(i));
    run_capture("decim", 8'h80, 0, 1, 3, 3);

    // Falling edge at 0x40
    stim = '{8'h30, 8'h50, 8'h40};
    run_capture("fall", 8'h40, 1, 0, 1, 1);

    // Abort keeps partial data; arm restarts; reset discards
    wr(16'h0004, 32'h0000_0200, 4'hF);
    wr(16'h0008, 32'd1, 4'hF);
    wr(16'h000C, 32'd10, 4'hF);
    wr(16'h0000, 32'h1, 4'hF);
    feed(8'h21, f);
    chk("abort_trig", {31'd0, f}, 32'd1);
    feed(8'h22, f);
    rd_chk("cap_status", 16'h0000, 32'h0002_0102, 1);
    wr(16'h0000, 32'h3, 4'h1);
    rd_chk("abort_status", 16'h0000, 32'h0002_0100, 1);
    rd_chk("abort_data", 16'h0010, 32'h8000_0021, 2);
    wr(16'h0000, 32'h1, 4'h1);
    feed(8'h33, f);
    wr(16'h0000, 32'h1, 4'h1);
    rd_chk("rearm_status", 16'h0000, 32'h0000_0001, 1);
    feed(8'h44, f);
    feed(8'h45, f);
    @(negedge clk); resetn = 1'b0;
    @(negedge clk); resetn = 1'b1;
    chk("mid_rst_cap_done", {31'd0, capture_done}, 32'd0);
    rd_chk("mid_rst_status", 16'h0000, 32'h0000_0000, 1);
    rd_chk("mid_rst_trig", 16'h0004, 32'h0000_0080, 1);
    rd_chk("mid_rst_decim", 16'h0008, 32'h0000_0001, 1);
    rd_chk("mid_rst_count", 16'h000C, 32'h0000_0000, 1);
    rd_chk("mid_rst_rdptr", 16'h0014, 32'h0000_0000, 1);

    // COUNT = 0 means the full 16-sample buffer
    stim.delete();
    for (int i = 0; i < 20; i++) stim.push_back(8'($urandom_range(0, 255)));
    run_capture("full", 8'h80, 0, 1, 1, 0);

    // Byte enables: upper DECIM byte untouched when only byte 0 is enabled
    wr(16'h0008, 32'h0000_1234, 4'h3);
    wr(16'h0008, 32'h0000_FF56, 4'h1);
    rd_chk("decim_be", 16'h0008, 32'h0000_1256, 1);
    wr(16'h0014, 32'd0, 4'h8);
    rd_chk("rdptr_clr", 16'h0014, 32'd0, 1);

    // Randomized captures
    for (int r = 0; r < 6; r++) begin
      stim.delete();
      for (int i = 0; i < 24; i++) stim.push_back(8'($urandom_range(0, 255)));
      run_capture("rand", int'($urandom_range(40, 215)), int'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0) ? 1 : 0, int'($urandom_range(1, 3)),
                  int'($urandom_range(1, 6)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/icosoc_mod_adc_capture.md
Name: icosoc_mod_adc_capture

Overview:
Triggered sample-capture stage placed directly downstream of the 8-bit parallel ADC input module. Consumes the registered ADC byte stream, applies decimation and a level/edge trigger, and stores a block of samples into an on-chip buffer. The CPU configures, arms and reads the buffer over the standard icosoc ctrl register bus.

Parameters:
CLOCK_FREQ_HZ, 0, unused; present so every mod instantiates uniformly
ADDR_BITS, 9, log2 of buffer depth; DEPTH = 2**ADDR_BITS samples of 8 bits

Ports:
clk  input  1  system clock; all logic on rising edge
resetn  input  1  synchronous active-low reset, sampled on rising clk
ctrl_wr  input  4  per-byte write enables for the ctrl bus
ctrl_rd  input  1  ctrl bus read request
ctrl_addr  input  16  register byte address
ctrl_wdat  input  32  write data
ctrl_rdat  output  32  read data, registered
ctrl_done  output  1  one-cycle transaction-complete pulse, registered
sample_data  input  8  ADC sample from the upstream stage
sample_valid  input  1  one-cycle strobe qualifying sample_data
capture_done  output  1  high while FSM is in DONE (interrupt-style level)
trig_pulse  output  1  one-cycle pulse on the cycle the trigger fires

Behaviour:
- Reset (resetn=0 at a clk edge): state IDLE; level=0x80, edge=0, immediate=0, decim=1, count=0; wr_ptr=rd_ptr=0; triggered=0; decimation counter=0; ctrl_done=0, ctrl_rdat=0, capture_done=0, trig_pulse=0. Reset mid-capture discards the capture. Buffer contents are undefined after reset.
- Bus handshake: a request is ctrl_rd or any ctrl_wr bit, with ctrl_done=0. Registers other than 0x10 assert ctrl_done 1 cycle after the request. Reads of 0x10 assert ctrl_done 2 cycles after the request, because the buffer read is registered. The master holds the request until ctrl_done. ctrl_rdat=0 on every cycle except the ctrl_done cycle of a read. Writes honour byte enables. Unmapped addresses complete normally: reads return 0, writes are ignored.
- Register map:
  - 0x00 CTRL/STATUS.
    - Write: bit0 arm, bit1 abort. If both are set, abort wins.
    - Read: [1:0] state (0 IDLE, 1 ARMED, 2 CAPTURE, 3 DONE), [8] triggered, [31:16] wr_ptr.
  - 0x04 TRIG: [7:0] level, [8] edge (0 rising, 1 falling), [9] immediate.
  - 0x08 DECIM: [15:0] divisor. A value of 0 is treated as 1.
  - 0x0C COUNT: [15:0] samples to capture. 0, or any value > DEPTH, means DEPTH.
  - 0x10 DATA (read only): [7:0] buffer[rd_ptr], [31] valid.
    - If rd_ptr < wr_ptr: valid=1 and rd_ptr increments.
    - Otherwise: the word is 0 with valid=0, and rd_ptr is unchanged.
  - 0x14 RDPTR: read returns rd_ptr; any write sets rd_ptr=0.
- Config latching: TRIG, DECIM and COUNT are writable in any state. The FSM uses shadow copies latched at arm.
- Arm: accepted in any state. Latches config, clears wr_ptr, rd_ptr, triggered, prev-valid and the decimation counter, then enters ARMED. Arm during CAPTURE restarts the capture.
- Abort: enters IDLE from any state. wr_ptr is retained, so partial data stays readable.
- Decimation: the counter runs on sample_valid strobes. A strobe is qualified when the counter equals 0; the counter then reloads to decim-1, otherwise it decrements.
- FSM transitions:
  - IDLE: holds until arm.
  - ARMED, immediate=1: the first qualified sample fires the trigger.
  - ARMED, immediate=0:
    - The first qualified sample after arm only loads prev.
    - Rising edge fires when prev < level and cur >= level.
    - Falling edge fires when prev > level and cur <= level.
    - prev is updated on every qualified sample.
  - On fire: triggered=1, trig_pulse=1 for that cycle, the firing sample is written to buffer[0], wr_ptr=1, state CAPTURE. If count=1, go directly to DONE.
  - CAPTURE: each qualified sample writes buffer[wr_ptr] and increments wr_ptr. When wr_ptr reaches count, go to DONE. The pointer never wraps or overwrites.
  - DONE: capture_done=1. Holds until arm or abort.
- wr_ptr width is ADDR_BITS+1. Samples arriving outside ARMED/CAPTURE are ignored.

Test Plan:
- Reset, then read 0x00, 0x04, 0x08 -> 0x00000000, 0x00000080, 0x00000001; ctrl_done is one pulse per read, 1 cycle after the request.
- TRIG=0x080 (rising, level 0x80), COUNT=4, arm; feed 0x10,0x7F,0x80,0x90,0xA0,0xB0,0xC0 -> trig_pulse on the 0x80 sample; DONE with wr_ptr=4; DATA reads return 0x80000080, 0x80000090, 0x800000A0, 0x800000B0, then 0x00000000; each DATA ctrl_done comes 2 cycles after the request.
- DECIM=3, immediate=1, COUNT=3; feed ramp 0..11 -> buffer holds 0,3,6; STATUS [1:0]=3 and [31:16]=3.
- Falling edge at level 0x40; feed 0x30,0x50,0x40 -> no fire on 0x30; fire on 0x40 (prev 0x50 > 0x40 and cur <= 0x40).
- Arm, feed 2 samples into CAPTURE with COUNT=10, write arm|abort -> IDLE, wr_ptr=2; arm alone mid-capture -> ARMED with wr_ptr=0; assert resetn=0 mid-capture -> all reset values.
- COUNT=0 with ADDR_BITS=4 -> exactly 16 samples captured; the 17th DATA read returns valid=0 and rd_ptr stays at 16.
